// File: rtl/tm1638_pkg.sv
// Shared constants and FSM encoding for the TM1638 front-panel transmit path.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP      = 8'h80;
    localparam int unsigned NUM_DIGIT_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic [7:0] disp_ctrl(input logic on, input logic [2:0] level);
        return CMD_DISP | {4'b0000, on, level};
    endfunction

endpackage

// File: rtl/tm1638_byte_shifter.sv
// Shifts one byte LSB first as 2*CLK_DIV-cycle bit cells on clk/dio.
module tm1638_byte_shifter #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic       clk,
    output logic       dio,
    output logic       byte_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy;
    logic             high;
    logic [DIV_W-1:0] div;
    logic [2:0]       bit_cnt;
    logic [6:0]       sh;

    // Combinational so the sequencer can load the next byte in the same cycle.
    assign byte_done = busy && high && (div == DIV_LAST) && (bit_cnt == 3'd7);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            busy    <= 1'b0;
            high    <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            clk     <= 1'b1;
            dio     <= 1'b1;
        end else if (load) begin
            busy    <= 1'b1;
            high    <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= load_byte[7:1];
            clk     <= 1'b0;
            dio     <= load_byte[0];
        end else if (busy) begin
            if (div == DIV_LAST) begin
                div <= '0;
                if (!high) begin
                    high <= 1'b1;
                    clk  <= 1'b1;
                end else if (bit_cnt == 3'd7) begin
                    busy <= 1'b0;
                    high <= 1'b0;
                    clk  <= 1'b1;
                    dio  <= 1'b1;
                end else begin
                    high    <= 1'b0;
                    bit_cnt <= bit_cnt + 3'd1;
                    clk     <= 1'b0;
                    dio     <= sh[0];
                    sh      <= {1'b0, sh[6:1]};
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm1638_frame_tx.sv
// Sequences the TM1638 data, address+image and display-control commands on stb.
module tm1638_frame_tx
    import tm1638_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25,
    parameter int unsigned STB_GAP = 50
) (
    input  logic         _50MHz_CLK,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] seg_data,
    input  logic [2:0]   brightness,
    input  logic         display_on,
    output logic         ready,
    output logic         done,
    output logic         clk,
    output logic         stb,
    output logic         dio
);

    localparam int unsigned CNT_MAX = (CLK_DIV > STB_GAP) ? CLK_DIV : STB_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STB_GAP - 1);
    localparam logic [4:0] CMD2_BYTES = 5'(NUM_DIGIT_BYTES + 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cmd_idx;
    logic [4:0]       byte_idx;
    logic [127:0]     seg_q;
    logic [2:0]       bright_q;
    logic             on_q;
    logic             accept, load, byte_done, last_byte;
    logic [7:0]       load_byte;
    logic [3:0]       digit;

    assign accept = start & ready;

    always_comb begin
        digit     = 4'(byte_idx - 5'd1);
        load_byte = CMD_DATA_AUTO;
        case (cmd_idx)
            2'd0:    load_byte = CMD_DATA_AUTO;
            2'd1:    load_byte = (byte_idx == 5'd0) ? CMD_ADDR0 : seg_q[{digit, 3'b000} +: 8];
            default: load_byte = disp_ctrl(on_q, bright_q);
        endcase
        // byte_idx counts bytes already loaded for the current command.
        last_byte = (cmd_idx == 2'd1) ? (byte_idx == CMD2_BYTES) : (byte_idx == 5'd1);
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            ST_IDLE:  if (accept) state_n = ST_SETUP;
            ST_SETUP: if (cnt == DIV_LAST) begin
                          state_n = ST_SHIFT;
                          load    = 1'b1;
                      end
            ST_SHIFT: if (byte_done) begin
                          if (last_byte) state_n = ST_HOLD;
                          else           load    = 1'b1;
                      end
            ST_HOLD:  if (cnt == DIV_LAST) state_n = ST_GAP;
            ST_GAP:   if (cnt == GAP_LAST) state_n = (cmd_idx == 2'd2) ? ST_DONE : ST_SETUP;
            ST_DONE:  state_n = accept ? ST_SETUP : ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge _50MHz_CLK) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cmd_idx  <= '0;
            byte_idx <= '0;
            seg_q    <= '0;
            bright_q <= '0;
            on_q     <= 1'b0;
            stb      <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)      cnt <= '0;
            else if (state != ST_SHIFT) cnt <= cnt + 1'b1;

            stb   <= !(state_n inside {ST_SETUP, ST_SHIFT, ST_HOLD});
            ready <= (state_n inside {ST_IDLE, ST_DONE});
            done  <= (state_n == ST_DONE);

            if (accept) begin
                seg_q    <= seg_data;
                bright_q <= brightness;
                on_q     <= display_on;
                cmd_idx  <= '0;
            end else if (state == ST_GAP && state_n == ST_SETUP) begin
                cmd_idx <= cmd_idx + 2'd1;
            end

            if (load)                   byte_idx <= byte_idx + 5'd1;
            else if (state_n == ST_SETUP) byte_idx <= '0;
        end
    end

    tm1638_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .sys_clk  (_50MHz_CLK),
        .rst      (rst),
        .load     (load),
        .load_byte(load_byte),
        .clk      (clk),
        .dio      (dio),
        .byte_done(byte_done)
    );

endmodule
